// File: rtl/wb_pic8259_if.sv
// Wishbone I/O slave bundle for the 8259-style PIC at ports 0x20/0x21.
// Byte lane 0 carries port 0x20 and byte lane 1 carries port 0x21.
interface wb_pic8259_if;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_pic8259.sv
// Cut-down 8259A-compatible interrupt controller: fixed priority (bit 0 highest),
// edge-triggered requests, ICW1/ICW2/ICW4 init, OCW2 EOI, OCW3 read-select.
module wb_pic8259 #(
    parameter logic [7:0] VEC_BASE = 8'h08
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    wb_pic8259_if.slave wb,
    input  logic [7:0]  irq_i,
    output logic        intr_o,
    input  logic        inta_i,
    output logic [7:0]  vec_o
);

    typedef enum logic [1:0] {StReady, StWaitIcw2, StWaitIcw4} init_st_e;

    // Index of the lowest set bit, i.e. the highest-priority request.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    init_st_e    st_q, st_d;
    logic [7:0]  irr_q, irr_d;
    logic [7:0]  isr_q, isr_d;
    logic [7:0]  imr_q, imr_d;
    logic [4:0]  base_q, base_d;
    logic        rd_isr_q, rd_isr_d;
    logic        need_icw4_q, need_icw4_d;
    logic [7:0]  irq_d_q;
    logic        inta_d_q;
    logic        ack_q, ack_d;
    logic [15:0] dat_q, dat_d;
    logic        intr_q, intr_d;
    logic [7:0]  vec_q, vec_d;

    logic        bus_req;
    logic        wr_en;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        inta_rise;
    logic [7:0]  pend_w;
    logic [2:0]  ack_idx;
    logic [7:0]  pend_q;

    assign bus_req   = wb.wb_stb_i & wb.wb_cyc_i;
    // Writes commit on the cycle the ack is presented, so each transfer acts once.
    assign wr_en     = bus_req & wb.wb_we_i & ack_q;
    assign lo        = wb.wb_dat_i[7:0];
    assign hi        = wb.wb_dat_i[15:8];
    assign inta_rise = inta_i & ~inta_d_q;
    assign ack_d     = bus_req & ~ack_q;
    assign dat_d     = ack_d ? {imr_q, (rd_isr_q ? isr_q : irr_q)} : dat_q;

    assign pend_q = irr_q & ~imr_q;
    assign intr_d = (pend_q != 8'h00) &&
                    ((isr_q == 8'h00) || (lowest_idx(pend_q) < lowest_idx(isr_q)));

    always_comb begin
        st_d        = st_q;
        irr_d       = irr_q;
        isr_d       = isr_q;
        imr_d       = imr_q;
        base_d      = base_q;
        rd_isr_d    = rd_isr_q;
        need_icw4_d = need_icw4_q;
        vec_d       = vec_q;
        pend_w      = 8'h00;
        ack_idx     = 3'd0;

        // Port 0x20: ICW1 from any state, OCW2/OCW3 only once initialised.
        if (wr_en && wb.wb_sel_i[0]) begin
            if (lo[4]) begin
                irr_d       = 8'h00;
                isr_d       = 8'h00;
                imr_d       = 8'h00;
                rd_isr_d    = 1'b0;
                need_icw4_d = lo[0];
                st_d        = StWaitIcw2;
            end else if (st_q == StReady) begin
                if (!lo[3]) begin
                    if (lo[7:5] == 3'b001) begin
                        if (isr_d != 8'h00) isr_d[lowest_idx(isr_d)] = 1'b0;
                    end else if (lo[7:5] == 3'b011) begin
                        isr_d[lo[2:0]] = 1'b0;
                    end
                end else begin
                    if (lo[1:0] == 2'b10) rd_isr_d = 1'b0;
                    else if (lo[1:0] == 2'b11) rd_isr_d = 1'b1;
                end
            end
        end

        // Port 0x21 sees the state left by a same-transfer port 0x20 write.
        if (wr_en && wb.wb_sel_i[1]) begin
            case (st_d)
                StWaitIcw2: begin
                    base_d = hi[7:3];
                    st_d   = need_icw4_d ? StWaitIcw4 : StReady;
                end
                StWaitIcw4: st_d = StReady;
                default:    imr_d = hi;
            endcase
        end

        // Acknowledge works on post-write state so a coincident EOI is honoured first.
        pend_w = irr_d & ~imr_d;
        if (inta_rise) begin
            if (pend_w != 8'h00) begin
                ack_idx        = lowest_idx(pend_w);
                irr_d[ack_idx] = 1'b0;
                isr_d[ack_idx] = 1'b1;
                vec_d          = {base_d, ack_idx};
            end else begin
                vec_d = {base_d, 3'd7};
            end
        end

        // New edges land last so a request on the bit being acked stays latched.
        irr_d = irr_d | (irq_i & ~irq_d_q);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            st_q        <= StReady;
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            imr_q       <= 8'hFF;
            base_q      <= VEC_BASE[7:3];
            rd_isr_q    <= 1'b0;
            need_icw4_q <= 1'b0;
            irq_d_q     <= 8'h00;
            inta_d_q    <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= 16'h0000;
            intr_q      <= 1'b0;
            vec_q       <= 8'h00;
        end else begin
            st_q        <= st_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            base_q      <= base_d;
            rd_isr_q    <= rd_isr_d;
            need_icw4_q <= need_icw4_d;
            irq_d_q     <= irq_i;
            inta_d_q    <= inta_i;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            intr_q      <= intr_d;
            vec_q       <= vec_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign intr_o      = intr_q;
    assign vec_o       = vec_q;

endmodule

// File: doc/wb_pic8259.md
Name: wb_pic8259

Overview:
- Cut-down 8259A-compatible programmable interrupt controller, a drop-in replacement for the fixed-priority simple PIC.
- Consumes the interrupt-request lines from the timer (bit 0), keyboard (bit 1) and COM1 UART (bit 4), and drives the CPU's interrupt request input.
- Answers the CPU's interrupt-acknowledge handshake with a full 8-bit vector.
- Exposes IMR/IRR/ISR and EOI to software as a Wishbone I/O slave at ports 0x20/0x21. The top-level decoder gates stb with the 0x20 arena.

Parameters:
- VEC_BASE, 8'h08, vector base loaded at reset; bits [2:0] ignored.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-low
- wb_dat_i  in  16  write data: [7:0] port 0x20, [15:8] port 0x21
- wb_dat_o  out  16  read data, same byte lanes
- wb_sel_i  in  2  byte select: [0] port 0x20, [1] port 0x21
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe (pre-decoded)
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  acknowledge
- irq_i  in  8  interrupt requests, synchronous to wb_clk_i, rising-edge sensitive
- intr_o  out  1  interrupt request to CPU
- inta_i  in  1  interrupt acknowledge from CPU, level, held high for the whole ack cycle
- vec_o  out  8  interrupt vector, valid while inta_i is high

Behaviour:
- Reset (async, active-low):
  - registers: IRR=0, ISR=0, IMR=8'hFF, base=VEC_BASE[7:3], read-select=IRR, init FSM=READY, irq/inta delay regs=0
  - outputs: wb_ack_o=0, intr_o=0, vec_o=0, wb_dat_o=0
- Edge detect: irq_d <= irq_i. Any bit with irq_i & ~irq_d sets the corresponding IRR bit on the next edge.
- Priority: fixed, bit 0 highest.
  - pend = IRR & ~IMR.
  - intr_o (registered) = 1 when the highest pend bit has higher priority than the highest ISR bit, or ISR=0.
- Ack handshake, on the rising edge of inta_i (inta_i & ~inta_d):
  - With pend≠0: highest pend bit n moves IRR→ISR; vec_o <= {base,n}.
  - With pend=0 (spurious): vec_o <= {base,3'd7}; IRR/ISR unchanged.
  - vec_o is held until the next inta rising edge.
  - intr_o re-evaluates from the updated state one cycle later.
- Simultaneous events:
  - New irq edge on the same bit being acked: that IRR bit stays set.
  - EOI write and inta edge in the same cycle: EOI applied first; the ack uses the post-EOI ISR.
- Wishbone:
  - wb_ack_o <= stb&cyc&~wb_ack_o, giving a 1-cycle pulse one clock after the strobe.
  - Write side effects take place on the ack cycle only, exactly once per transfer.
  - wb_dat_o is registered with the ack: [7:0] = IRR or ISR per read-select, [15:8] = IMR.
  - Reads have no side effects. A cycle dropped before ack has no effect.
- Port 0x20 write (sel[0]), decoded in the READY state:
  - d[4]=1 (ICW1): IRR=0, ISR=0, IMR=0, read-select=IRR; FSM→WAIT_ICW2; latch need_icw4=d[0].
  - d[4:3]=00 (OCW2): d[7:5]=001 is non-specific EOI, clearing the highest-priority ISR bit (no-op if ISR=0). d[7:5]=011 is specific EOI, clearing ISR[d[2:0]]. Other codes are ignored.
  - d[4:3]=01 (OCW3): d[1:0]=10 sets read-select=IRR; d[1:0]=11 sets read-select=ISR; others ignored.
- Port 0x21 write (sel[1]), by init-FSM state:
  - WAIT_ICW2: base <= d[15:11]; →WAIT_ICW4 if need_icw4, else READY.
  - WAIT_ICW4: data discarded; →READY.
  - READY: IMR <= d[15:8].
- Both sel bits set on one write: the port 0x20 action is evaluated first, then port 0x21 against the updated FSM state.
- An ICW1 write in any FSM state restarts initialisation.
- Masking a bit pending in IRR keeps it latched. Unmasking later raises intr_o.

Test Plan:
- Reset → intr_o=0, vec_o=00, IMR reads FF. Pulse irq_i[0] → no intr_o; IRR reads 01.
- Write 0x21=FC, pulse irq_i[0] → intr_o=1 within 2 cycles. inta_i high → vec_o=08, ISR=01, intr_o=0. Write 0x20=20 → ISR=00.
- Priority/nesting: IMR=00, pulse irq_i[4] and ack (vec 0C, ISR=10). Pulse irq_i[1] → intr_o=1, ack vec 09, ISR=12. Non-specific EOI → ISR=10. Specific EOI 0x64 → ISR=00.
- Init sequence 0x20=11, 0x21=70, 0x21=01 → IMR=00, FSM READY. Pulse irq_i[1] → vector 71.
- Spurious: IRQ pending, then IMR=FF before inta → vec_o=0F, ISR unchanged, IRR bit still set. Unmask → intr_o=1.
- Assert wb_rst_i low mid Wishbone cycle with ISR=01 → ack drops immediately; all registers return to their reset values asynchronously.
